lbp_img_server: RTL

Memory-side responder for the LBP engine's two interfaces: it holds the 128×128 grayscale image and answers `gray_req`/`gray_addr` with `gray_data`, and it captures every `lbp_valid` write into a result store. Images are loaded from a host stream. Results are read back after `finish`. It sits between the host/test harness and the LBP engine, replacing behavioural memories with synthesizable logic.

---
 rtl/lbp_pkg.sv | 28 ++
 rtl/lbp_dp_ram.sv | 46 ++++
 rtl/lbp_img_server.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP image server: FSM state encoding,
// default image geometry, expected interior-result count and a border test.
package lbp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StServe,
    StDone
  } lbp_state_e;

  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned IMG_H_DEF = 128;

  // One result per interior pixel; the one-pixel frame has no full 3x3 window.
  localparam int unsigned LBP_EXPECT = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

  // True when a raster address lies on the outer frame of a w x h image.
  function automatic logic is_border(input int unsigned addr, input int unsigned w,
                                     input int unsigned h);
    int unsigned col;
    int unsigned row;
    col = addr % w;
    row = addr / w;
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/lbp_dp_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port and an
// optional registered read port (REG_RD_EN) whose output is zero when i_re is low.
module lbp_dp_ram #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 14,
  parameter bit          REG_RD_EN = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_araddr,
  output logic [DW-1:0] o_ardata,
  input  logic          i_re,
  input  logic [AW-1:0] i_rraddr,
  output logic [DW-1:0] o_rrdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Write port: commits on the clock edge where i_we is high.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_ardata = r_mem[i_araddr];

  if (REG_RD_EN) begin : g_reg_rd
    logic [DW-1:0] r_rdata;

    // Registered read: one cycle latency, forced to zero while not enabled.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_rraddr];
      else           r_rdata <= '0;
    end

    assign o_rrdata = r_rdata;
  end else begin : g_no_reg_rd
    logic w_unused;
    assign w_unused = ^{i_rst_n, i_re, i_rraddr};
    assign o_rrdata = '0;
  end

endmodule

// File: rtl/lbp_img_server.sv
// Memory-side responder for the LBP engine: loads a raster image from a host
// stream, serves combinational gray reads, captures result writes and offers
// registered readback once the engine signals finish.
// Optional protocol checking is enabled by defining LBP_SRV_CHECK_EN.
module lbp_img_server
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned AW    = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_valid,
  input  logic [7:0]    i_load_data,
  output logic          o_gray_ready,
  input  logic          i_gray_req,
  input  logic [AW-1:0] i_gray_addr,
  output logic [7:0]    o_gray_data,
  input  logic          i_lbp_valid,
  input  logic [AW-1:0] i_lbp_addr,
  input  logic [7:0]    i_lbp_data,
  input  logic          i_finish,
  output logic          o_done,
  output logic [AW:0]   o_lbp_cnt,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_err
);

  lbp_state_e    r_state;
  logic [AW-1:0] r_ld_cnt;
  logic [AW:0]   r_lbp_cnt;
  logic          r_gray_ready;
  logic          r_done;

  logic          w_img_we;
  logic          w_ld_last;
  logic          w_res_we;
  logic          w_to_done;
  logic [7:0]    w_img_rdata;
  logic [7:0]    w_img_unused;
  logic [7:0]    w_res_unused;

  // IDLE accepts pixels too, so the first cycle after reset release is not lost.
  assign w_img_we  = i_load_valid && ((r_state == StIdle) || (r_state == StLoad));
  assign w_ld_last = (r_ld_cnt == AW'(IMG_W * IMG_H - 1));
  assign w_res_we  = i_lbp_valid && (r_state == StServe);
  assign w_to_done = i_finish && (r_state == StServe);

  // Control FSM with registered status flags and counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_ld_cnt     <= '0;
      r_lbp_cnt    <= '0;
      r_gray_ready <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_img_we) r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + AW'(1);
      if (w_res_we) r_lbp_cnt <= r_lbp_cnt + (AW+1)'(1);
      case (r_state)
        StIdle, StLoad: begin
          if (w_img_we && w_ld_last) begin
            r_state      <= StServe;
            r_gray_ready <= 1'b1;
          end else begin
            r_state <= StLoad;
          end
        end
        StServe: begin
          if (i_finish) begin
            r_state      <= StDone;
            r_gray_ready <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        StDone:  r_state <= StDone;
        default: r_state <= StIdle;
      endcase
    end
  end

  lbp_dp_ram #(
    .DW        (8),
    .AW        (AW),
    .REG_RD_EN (1'b0)
  ) u_img_ram (
    .i_clk    (i_clk),
    .i_rst_n  (i_reset),
    .i_we     (w_img_we),
    .i_waddr  (r_ld_cnt),
    .i_wdata  (i_load_data),
    .i_araddr (i_gray_addr),
    .o_ardata (w_img_rdata),
    .i_re     (1'b0),
    .i_rraddr (i_gray_addr),
    .o_rrdata (w_img_unused)
  );

  lbp_dp_ram #(
    .DW        (8),
    .AW        (AW),
    .REG_RD_EN (1'b1)
  ) u_res_ram (
    .i_clk    (i_clk),
    .i_rst_n  (i_reset),
    .i_we     (w_res_we),
    .i_waddr  (i_lbp_addr),
    .i_wdata  (i_lbp_data),
    .i_araddr (i_rd_addr),
    .o_ardata (w_res_unused),
    .i_re     (r_state == StDone),
    .i_rraddr (i_rd_addr),
    .o_rrdata (o_rd_data)
  );

  assign o_gray_data  = (i_gray_req && (r_state == StServe)) ? w_img_rdata : 8'd0;
  assign o_gray_ready = r_gray_ready;
  assign o_done       = r_done;
  assign o_lbp_cnt    = r_lbp_cnt;

`ifdef LBP_SRV_CHECK_EN
  localparam int unsigned LbpExpect = (IMG_W - 2) * (IMG_H - 2);

  logic [AW:0] w_cnt_next;
  logic        w_err_set;
  logic        r_err;

  // Count as it will stand after this edge, so a write alongside finish is included.
  assign w_cnt_next = r_lbp_cnt + {{AW{1'b0}}, w_res_we};
  assign w_err_set  = (i_lbp_valid && (r_state != StServe))
                   || (i_lbp_valid && is_border(32'(i_lbp_addr), IMG_W, IMG_H))
                   || (i_gray_req && (r_state != StServe))
                   || (w_to_done && (w_cnt_next != (AW+1)'(LbpExpect)));

  // Sticky protocol error flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset)       r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule
